// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: FSM state encoding, access-size constants and small address helpers
// shared by the MIPS load/store controller and its lane-alignment logic.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   localparam logic [2:0] MEM_SZ_B = 3'd1;
   localparam logic [2:0] MEM_SZ_H = 3'd2;
   localparam logic [2:0] MEM_SZ_W = 3'd4;

   // Any encoding other than byte or halfword behaves as a full word.
   function automatic logic [2:0] norm_size(input logic [2:0] size);
      case (size)
         MEM_SZ_B: return MEM_SZ_B;
         MEM_SZ_H: return MEM_SZ_H;
         default:  return MEM_SZ_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offset);
      case (size)
         MEM_SZ_B: return 1'b0;
         MEM_SZ_H: return offset[0];
         default:  return |offset;
      endcase
   endfunction

   // Byte offset after rounding the address down to the access-size boundary.
   function automatic logic [1:0] align_offset(input logic [2:0] size, input logic [1:0] offset);
      case (size)
         MEM_SZ_B: return offset;
         MEM_SZ_H: return {offset[1], 1'b0};
         default:  return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mips_mem_align.sv
// mips_mem_align: combinational lane logic for the load/store controller -- byte enables,
// store-data replication across lanes and load-lane selection with sign/zero extension.
module mips_mem_align
   import mips_mem_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  byte_en,
   output logic [31:0] lane_wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Pick the addressed byte and halfword out of the returned word.
   always_comb begin
      byte_lane = load_word[7:0];
      case (offset)
         2'd0: byte_lane = load_word[7:0];
         2'd1: byte_lane = load_word[15:8];
         2'd2: byte_lane = load_word[23:16];
         2'd3: byte_lane = load_word[31:24];
         default: byte_lane = load_word[7:0];
      endcase
      half_lane = offset[1] ? load_word[31:16] : load_word[15:0];
   end

   // Store data is replicated so whichever lanes are enabled carry the right bytes.
   always_comb begin
      byte_en    = 4'b1111;
      lane_wdata = store_data;
      load_data  = load_word;
      case (size)
         MEM_SZ_B: begin
            byte_en    = 4'b0001 << offset;
            lane_wdata = {4{store_data[7:0]}};
            load_data  = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
         end
         MEM_SZ_H: begin
            byte_en    = 4'b0011 << offset;
            lane_wdata = {2{store_data[15:0]}};
            load_data  = {{16{~is_unsigned & half_lane[15]}}, half_lane};
         end
         default: begin
            byte_en    = 4'b1111;
            lane_wdata = store_data;
            load_data  = load_word;
         end
      endcase
   end

endmodule

// File: rtl/mips_mem_ctrl.sv
// mips_mem_ctrl: sequences MIPS loads/stores over a req/gnt/rvalid data-memory port.
// Define MIPS_MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses via adel/ades.
module mips_mem_ctrl
   import mips_mem_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        op_valid,
   input  logic        op_load,
   input  logic [2:0]  op_size,
   input  logic        op_unsigned,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        adel,
   output logic        ades,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   mem_state_e        state_q, state_d;
   logic              load_q, load_d;
   logic [2:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;
   logic [29:0]       word_q, word_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              bus_err_q, bus_err_d;
   logic [2:0]        op_size_n;
   logic              trap_hit;
   logic [3:0]        byte_en;
   logic [31:0]       lane_wdata;
   logic [31:0]       load_data;
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
   logic              trap_q, trap_d;
`endif

   assign op_size_n = norm_size(op_size);

`ifdef MIPS_MEM_MISALIGN_TRAP_EN
   assign trap_hit = is_misaligned(op_size_n, op_addr[1:0]);
`else
   assign trap_hit = 1'b0;
`endif

   mips_mem_align u_align (
      .size        (size_q),
      .offset      (off_q),
      .is_unsigned (unsigned_q),
      .store_data  (wdata_q),
      .load_word   (mem_rdata),
      .byte_en     (byte_en),
      .lane_wdata  (lane_wdata),
      .load_data   (load_data)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= ST_IDLE;
         load_q     <= 1'b0;
         size_q     <= MEM_SZ_W;
         unsigned_q <= 1'b0;
         word_q     <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         bus_err_q  <= 1'b0;
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
         trap_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         load_q     <= load_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         word_q     <= word_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         bus_err_q  <= bus_err_d;
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
         trap_q     <= trap_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (op_valid) state_d = trap_hit ? ST_DONE : ST_REQ;
         ST_REQ:  if (mem_gnt) state_d = ST_WAIT;
         ST_WAIT: if (mem_rvalid || (cnt_q == CNT_MAX)) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Op fields are captured once in IDLE; the address is rounded down to the size boundary here.
   always_comb begin
      load_d     = load_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      word_d     = word_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      bus_err_d  = bus_err_q;
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
      trap_d     = trap_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               load_d     = op_load;
               size_d     = op_size_n;
               unsigned_d = op_unsigned;
               word_d     = op_addr[31:2];
               off_d      = align_offset(op_size_n, op_addr[1:0]);
               wdata_d    = op_wdata;
               rdata_d    = '0;
               bus_err_d  = 1'b0;
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
               trap_d     = trap_hit;
`endif
            end
         end
         ST_REQ: cnt_d = '0;
         ST_WAIT: begin
            if (mem_rvalid) begin
               rdata_d = load_q ? load_data : 32'h0;
            end else if (cnt_q == CNT_MAX) begin
               bus_err_d = 1'b1;
               rdata_d   = 32'h0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Port outputs decode purely from state so a reset drops them in the same instant.
   always_comb begin
      stall     = 1'b0;
      done      = 1'b0;
      rdata     = 32'h0;
      adel      = 1'b0;
      ades      = 1'b0;
      bus_err   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_be    = 4'h0;
      mem_wdata = 32'h0;
      case (state_q)
         ST_IDLE: stall = op_valid;
         ST_REQ: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = ~load_q;
            mem_addr  = {word_q, 2'b00};
            mem_be    = byte_en;
            mem_wdata = lane_wdata;
         end
         ST_WAIT: stall = 1'b1;
         ST_DONE: begin
            done    = 1'b1;
            rdata   = rdata_q;
            bus_err = bus_err_q;
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
            adel    = trap_q & load_q;
            ades    = trap_q & ~load_q;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// tb_mips_mem_ctrl: table vectors, reset corner cases and randomized ops against a byte-level
// memory model; the bench itself plays the data-memory port.
module tb_mips_mem_ctrl;

   localparam int TB_MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        op_valid, op_load, op_unsigned;
   logic [2:0]  op_size;
   logic [31:0] op_addr, op_wdata;
   logic        stall, done, adel, ades, bus_err;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       name;
      bit          ld;
      logic [2:0]  size;
      bit          uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] memWord;
      int          gntDly;
      int          rvDly;
      bit          noRv;
      bit          junkRv;
      logic [31:0] expAddr;
      logic [3:0]  expBe;
      logic [31:0] expWdata;
      logic [31:0] expRdata;
      int          expDone;
      bit          expBusErr;
      bit          expAdel;
      bit          expAdes;
      bit          expNoReq;
   } vec_t;

   typedef struct {
      int          doneCyc;
      int          stallCyc;
      bit          reqSeen;
      bit          reqUnstable;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          busErr;
      bit          adel;
      bit          ades;
   } obs_t;

   logic [7:0] memBytes [int unsigned];
   vec_t tbl[$];

   mips_mem_ctrl #(.MAX_WAIT(TB_MAX_WAIT)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .op_valid   (op_valid),
      .op_load    (op_load),
      .op_size    (op_size),
      .op_unsigned(op_unsigned),
      .op_addr    (op_addr),
      .op_wdata   (op_wdata),
      .stall      (stall),
      .done       (done),
      .rdata      (rdata),
      .adel       (adel),
      .ades       (ades),
      .bus_err    (bus_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] memByte(input int unsigned a);
      logic [31:0] h;
      if (memBytes.exists(a)) return memBytes[a];
      h = a * 37 + 5;
      return h[7:0];
   endfunction

   function automatic vec_t mk(input string name, input bit ld, input logic [2:0] size, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] memWord,
                               input int gntDly, input int rvDly, input bit noRv);
      vec_t v;
      v.name = name; v.ld = ld; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.memWord = memWord; v.gntDly = gntDly; v.rvDly = rvDly; v.noRv = noRv; v.junkRv = 1'b0;
      v.expAddr = '0; v.expBe = '0; v.expWdata = '0; v.expRdata = '0; v.expDone = 0;
      v.expBusErr = 0; v.expAdel = 0; v.expAdes = 0; v.expNoReq = 0;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vin, input logic [31:0] expAddr, input logic [3:0] expBe,
                               input logic [31:0] expWdata, input logic [31:0] expRdata, input int expDone,
                               input bit busErr, input bit adelE, input bit adesE, input bit noReq);
      vec_t v = vin;
      v.expAddr = expAddr; v.expBe = expBe; v.expWdata = expWdata; v.expRdata = expRdata;
      v.expDone = expDone; v.expBusErr = busErr; v.expAdel = adelE; v.expAdes = adesE; v.expNoReq = noReq;
      return v;
   endfunction

   // Reference model: byte-addressed memory, size rounding, lane selection by arithmetic.
   function automatic vec_t modelOp(input vec_t vin);
      vec_t v = vin;
      int sz;
      int off;
      int unsigned eaddr;
      logic [31:0] word;
      logic [31:0] val;
      sz = (v.size == 3'd1) ? 1 : ((v.size == 3'd2) ? 2 : 4);
      v.expAdel = 0; v.expAdes = 0; v.expBusErr = 0; v.expNoReq = 0;
      v.expRdata = '0; v.expWdata = '0; v.expBe = '0;
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
      if ((v.addr % sz) != 0) begin
         v.expNoReq = 1; v.expDone = 1; v.expAdel = v.ld; v.expAdes = !v.ld;
         v.expAddr = '0; v.memWord = '0;
         return v;
      end
`endif
      eaddr = v.addr - (v.addr % sz);
      v.expAddr = eaddr & ~32'd3;
      off = eaddr % 4;
      word = '0;
      for (int lane = 0; lane < 4; lane++) begin
         word[8*lane +: 8] = memByte(v.expAddr + lane);
         if (lane >= off && lane < off + sz) v.expBe[lane] = 1'b1;
         v.expWdata[8*lane +: 8] = v.wdata[8*(lane % sz) +: 8];
      end
      v.memWord = word;
      if (v.noRv) begin
         v.expBusErr = 1;
         v.expDone = 2 + v.gntDly + TB_MAX_WAIT + 1;
      end else begin
         v.expDone = 3 + v.gntDly + v.rvDly;
         if (v.ld) begin
            val = '0;
            for (int i = 0; i < sz; i++) val[8*i +: 8] = word[8*(off + i) +: 8];
            if (!v.uns && sz < 4 && val[8*sz-1]) begin
               for (int i = sz; i < 4; i++) val[8*i +: 8] = 8'hFF;
            end
            v.expRdata = val;
         end else begin
            for (int lane = 0; lane < 4; lane++) begin
               if (v.expBe[lane]) memBytes[v.expAddr + lane] = v.expWdata[8*lane +: 8];
            end
         end
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Presents one op and acts as the memory port until done or the cycle budget runs out.
   task automatic applyStimulus(input vec_t v, output obs_t o);
      int cyc, reqCyc, waitIdx;
      bit inWait, finished;
      o.doneCyc = -1; o.stallCyc = 0; o.reqSeen = 0; o.reqUnstable = 0; o.we = 0;
      o.addr = '0; o.be = '0; o.wdata = '0; o.rdata = '0; o.busErr = 0; o.adel = 0; o.ades = 0;
      @(negedge clk);
      op_valid = 1'b1; op_load = v.ld; op_size = v.size; op_unsigned = v.uns;
      op_addr = v.addr; op_wdata = v.wdata;
      cyc = 0; reqCyc = 0; waitIdx = 0; inWait = 0; finished = 0;
      while (!finished && cyc < 40) begin
         #1;
         if (stall) o.stallCyc++;
         if (mem_req) begin
            if (!o.reqSeen) begin
               o.addr = mem_addr; o.be = mem_be; o.we = mem_we; o.wdata = mem_wdata;
            end else if (mem_addr !== o.addr || mem_be !== o.be || mem_we !== o.we || mem_wdata !== o.wdata) begin
               o.reqUnstable = 1;
            end
            o.reqSeen = 1;
            mem_gnt = (reqCyc == v.gntDly);
            if (v.junkRv) begin
               mem_rvalid = 1'b1;
               mem_rdata = $urandom;
            end
            reqCyc++;
         end
         if (inWait) begin
            if (!v.noRv && waitIdx == v.rvDly) begin
               mem_rvalid = 1'b1;
               mem_rdata = v.memWord;
            end
            waitIdx++;
         end
         if (done) begin
            o.doneCyc = cyc; o.rdata = rdata; o.busErr = bus_err; o.adel = adel; o.ades = ades;
            finished = 1;
         end
         @(negedge clk);
         if (mem_gnt) inWait = 1;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         cyc++;
      end
      op_valid = 1'b0;
   endtask

   task automatic checkVector(input vec_t v, input obs_t o);
      checkOutput({v.name, " done_cycle"}, o.doneCyc, v.expDone);
      checkOutput({v.name, " stall_cycles"}, o.stallCyc, v.expDone);
      checkOutput({v.name, " rdata"}, o.rdata, v.expRdata);
      checkOutput({v.name, " bus_err"}, o.busErr, v.expBusErr);
      checkOutput({v.name, " adel"}, o.adel, v.expAdel);
      checkOutput({v.name, " ades"}, o.ades, v.expAdes);
      checkOutput({v.name, " req_seen"}, o.reqSeen, !v.expNoReq);
      if (!v.expNoReq) begin
         checkOutput({v.name, " mem_addr"}, o.addr, v.expAddr);
         checkOutput({v.name, " mem_be"}, o.be, v.expBe);
         checkOutput({v.name, " mem_we"}, o.we, !v.ld);
         checkOutput({v.name, " req_stable"}, o.reqUnstable, 0);
         if (!v.ld) checkOutput({v.name, " mem_wdata"}, o.wdata, v.expWdata);
      end
   endtask

   task automatic resetMidAccess(input string name, input bit waitPhase);
      @(negedge clk);
      op_valid = 1'b1; op_load = 1'b1; op_size = 3'd4; op_unsigned = 1'b0;
      op_addr = 32'h400; op_wdata = '0;
      @(negedge clk);
      #1 checkOutput({name, " req_before"}, mem_req, 1);
      if (waitPhase) begin
         mem_gnt = 1'b1;
         @(negedge clk);
         mem_gnt = 1'b0;
         #1 checkOutput({name, " stall_before"}, stall, 1);
      end
      rst_b = 1'b0; op_valid = 1'b0;
      #1;
      checkOutput({name, " mem_req"}, mem_req, 0);
      checkOutput({name, " stall"}, stall, 0);
      checkOutput({name, " done"}, done, 0);
      @(negedge clk);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput({name, " idle_done"}, done, 0);
      checkOutput({name, " idle_stall"}, stall, 0);
   endtask

   initial begin
      obs_t o;
      vec_t v;
      rst_b = 1'b0; op_valid = 1'b0; op_load = 1'b0; op_size = 3'd4; op_unsigned = 1'b0;
      op_addr = '0; op_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset stall", stall, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset mem_req", mem_req, 0);
      checkOutput("reset rdata", rdata, 0);
      checkOutput("reset bus_err", bus_err, 0);
      checkOutput("reset adel_ades", {adel, ades}, 0);
      rst_b = 1'b1;

      tbl.push_back(ex(mk("lw_0x100", 1, 3'd4, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0),
                       32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3, 0, 0, 0, 0));
      tbl.push_back(ex(mk("lb_0x103", 1, 3'd1, 0, 32'h103, 32'h0, 32'h80123456, 0, 0, 0),
                       32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 3, 0, 0, 0, 0));
      tbl.push_back(ex(mk("lbu_0x103", 1, 3'd1, 1, 32'h103, 32'h0, 32'h80123456, 0, 0, 0),
                       32'h100, 4'b1000, 32'h0, 32'h00000080, 3, 0, 0, 0, 0));
      tbl.push_back(ex(mk("sh_0x202", 0, 3'd2, 0, 32'h202, 32'h1234, 32'h0, 2, 0, 0),
                       32'h200, 4'b1100, 32'h12341234, 32'h0, 5, 0, 0, 0, 0));
      tbl.push_back(ex(mk("lh_0x102", 1, 3'd2, 0, 32'h102, 32'h0, 32'hBEEF1234, 0, 1, 0),
                       32'h100, 4'b1100, 32'h0, 32'hFFFFBEEF, 4, 0, 0, 0, 0));
      tbl.push_back(ex(mk("lhu_0x100", 1, 3'd2, 1, 32'h100, 32'h0, 32'h12348001, 1, 0, 0),
                       32'h100, 4'b0011, 32'h0, 32'h00008001, 4, 0, 0, 0, 0));
      tbl.push_back(ex(mk("sb_0x105", 0, 3'd1, 0, 32'h105, 32'h123456AB, 32'h0, 0, 0, 0),
                       32'h104, 4'b0010, 32'hABABABAB, 32'h0, 3, 0, 0, 0, 0));
      tbl.push_back(ex(mk("sw_size3", 0, 3'd3, 0, 32'h10, 32'h11223344, 32'h0, 0, 2, 0),
                       32'h10, 4'b1111, 32'h11223344, 32'h0, 5, 0, 0, 0, 0));
      tbl.push_back(ex(mk("timeout_g0", 1, 3'd4, 0, 32'h300, 32'h0, 32'h0, 0, 0, 1),
                       32'h300, 4'b1111, 32'h0, 32'h0, 7, 1, 0, 0, 0));
      tbl.push_back(ex(mk("timeout_g1", 0, 3'd4, 0, 32'h304, 32'h55, 32'h0, 1, 0, 1),
                       32'h304, 4'b1111, 32'h55, 32'h0, 8, 1, 0, 0, 0));
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
      tbl.push_back(ex(mk("lw_0x101", 1, 3'd4, 0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, 0),
                       32'h0, 4'b0000, 32'h0, 32'h0, 1, 0, 1, 0, 1));
      tbl.push_back(ex(mk("sw_0x22", 0, 3'd4, 0, 32'h22, 32'h99, 32'h0, 0, 0, 0),
                       32'h0, 4'b0000, 32'h0, 32'h0, 1, 0, 0, 1, 1));
      tbl.push_back(ex(mk("lh_0x103", 1, 3'd2, 0, 32'h103, 32'h0, 32'h7F001234, 0, 0, 0),
                       32'h0, 4'b0000, 32'h0, 32'h0, 1, 0, 1, 0, 1));
`else
      tbl.push_back(ex(mk("lw_0x101", 1, 3'd4, 0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, 0),
                       32'h100, 4'b1111, 32'h0, 32'hCAFEF00D, 3, 0, 0, 0, 0));
      tbl.push_back(ex(mk("sw_0x22", 0, 3'd4, 0, 32'h22, 32'h99, 32'h0, 0, 0, 0),
                       32'h20, 4'b1111, 32'h99, 32'h0, 3, 0, 0, 0, 0));
      tbl.push_back(ex(mk("lh_0x103", 1, 3'd2, 0, 32'h103, 32'h0, 32'h7F001234, 0, 0, 0),
                       32'h100, 4'b1100, 32'h0, 32'h00007F00, 3, 0, 0, 0, 0));
`endif

      foreach (tbl[i]) begin
         applyStimulus(tbl[i], o);
         checkVector(tbl[i], o);
      end

      resetMidAccess("rst_in_req", 1'b0);
      resetMidAccess("rst_in_wait", 1'b1);
      v = tbl[0];
      v.name = "after_reset";
      applyStimulus(v, o);
      checkVector(v, o);

      for (int i = 0; i < 60; i++) begin
         v = mk($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 31)), $urandom,
                32'h0, $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
         v.junkRv = 1'($urandom_range(0, 1));
         v = modelOp(v);
         applyStimulus(v, o);
         checkVector(v, o);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
